// File: rtl/seg7_bcd_counter_mux.sv
// N-digit BCD up/down counter with prescaled tick, wrap strobe and multiplexed 7-segment scan.
// Optional build macro SEG7_LEADING_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module seg7_bcd_counter_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned TICK_DIV       = 1125000,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value_bcd,
  output logic                  wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;
  localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [PW-1:0]     r_presc;
  logic [SW-1:0]     r_scan;
  logic [IW-1:0]     r_idx;
  logic [VW-1:0]     r_value;
  logic              r_wrap;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  logic              w_tick;
  logic [VW-1:0]     w_next;
  logic              w_carry;
  logic [3:0]        w_dig;
  logic [DIGITS-1:0] w_blank;
  logic [3:0]        w_sel_dig;
  logic              w_sel_blank;
  logic [DIGITS-1:0] w_an;
  logic [6:0]        w_seg;

  assign w_tick = en && (r_presc == PW'(TICK_DIV - 1));

  // Active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b1111111;
    endcase
  endfunction

  // Ripple carry/borrow across digits; final w_carry is the wrap condition
  always_comb begin
    w_next  = r_value;
    w_carry = 1'b1;
    w_dig   = 4'd0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      w_dig = r_value[4*k +: 4];
      if (w_carry) begin
        if (up_dn) begin
          if (w_dig == 4'd9) begin
            w_next[4*k +: 4] = 4'd0;
          end else begin
            w_next[4*k +: 4] = w_dig + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (w_dig == 4'd0) begin
            w_next[4*k +: 4] = 4'd9;
          end else begin
            w_next[4*k +: 4] = w_dig - 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

`ifdef SEG7_LEADING_BLANK_EN
  logic w_zrun;
  always_comb begin
    w_blank = '0;
    w_zrun  = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      w_zrun     = w_zrun && (r_value[4*k +: 4] == 4'd0);
      w_blank[k] = w_zrun;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Select the scanned digit and build next seg/an
  always_comb begin
    w_sel_dig   = 4'd0;
    w_sel_blank = 1'b0;
    w_an        = '1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (IW'(k) == r_idx) begin
        w_sel_dig   = r_value[4*k +: 4];
        w_sel_blank = w_blank[k];
        w_an[k]     = 1'b0;
      end
    end
    if (w_sel_blank) begin
      w_seg = SEG_OFF;
    end else if (SEG_ACTIVE_LOW) begin
      w_seg = f_decode(w_sel_dig);
    end else begin
      w_seg = ~f_decode(w_sel_dig);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else if (clear) begin
      r_presc <= '0;
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (en) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
      if (w_tick) begin
        r_value <= w_next;
        r_wrap  <= w_carry;
      end
    end
  end

  // Free-running digit scan and registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_seg  <= SEG_OFF;
      r_an   <= '1;
    end else begin
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end else begin
        r_scan <= r_scan + SW'(1);
      end
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign value_bcd = r_value;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Directed bench for seg7_bcd_counter_mux with DIGITS=2, TICK_DIV=4, SCAN_DIV=2, active-low segments.
module tb_seg7_bcd_counter_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [7:0] value_bcd;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_bcd_counter_mux #(
    .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear),
    .seg(seg), .an(an), .value_bcd(value_bcd), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic wait_an(input logic [1:0] target, input string tag);
    int cnt;
    cnt = 0;
    while (an !== target && cnt < 20) begin
      step(1);
      cnt++;
    end
    check(tag, 32'(an), 32'(target));
  endtask

  initial begin
    // 1: reset mid-count at 37
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    step(148);
    check("pre_reset_value", 32'(value_bcd), 32'h37);
    rst = 1'b0;
    #1;
    check("rst_value", 32'(value_bcd), 32'h00);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'h3);
    check("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b1;

    // 2: count up, 99 -> 00 wrap
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    step(40);
    check("up_40", 32'(value_bcd), 32'h10);
    step(356);
    check("up_396", 32'(value_bcd), 32'h99);
    check("up_396_wrap", 32'(wrap), 32'h0);
    step(4);
    check("up_wrap_value", 32'(value_bcd), 32'h00);
    check("up_wrap_hi", 32'(wrap), 32'h1);
    step(1);
    check("up_wrap_lo", 32'(wrap), 32'h0);

    // 3: count down from 00
    do_reset();
    en = 1'b1; up_dn = 1'b0;
    step(4);
    check("dn_first", 32'(value_bcd), 32'h99);
    check("dn_wrap_hi", 32'(wrap), 32'h1);
    step(1);
    check("dn_wrap_lo", 32'(wrap), 32'h0);
    step(3);
    check("dn_second", 32'(value_bcd), 32'h98);
    check("dn_second_wrap", 32'(wrap), 32'h0);

    // 4: clear beats tick at 99 up, and restarts the prescaler
    do_reset();
    en = 1'b1; up_dn = 1'b0;
    step(4);
    up_dn = 1'b1;
    step(3);
    check("clr_pre", 32'(value_bcd), 32'h99);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_value", 32'(value_bcd), 32'h00);
    check("clr_wrap", 32'(wrap), 32'h0);
    step(3);
    check("clr_hold3", 32'(value_bcd), 32'h00);
    step(1);
    check("clr_tick4", 32'(value_bcd), 32'h01);
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_mid", 32'(value_bcd), 32'h00);
    step(3);
    check("clr_mid_hold", 32'(value_bcd), 32'h00);
    step(1);
    check("clr_mid_tick", 32'(value_bcd), 32'h01);

    // 5: enable low holds value and prescaler; scan keeps running
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    step(22);
    check("hold_start", 32'(value_bcd), 32'h05);
    en = 1'b0;
    up_dn = 1'b0;
    step(100);
    check("hold_value", 32'(value_bcd), 32'h05);
    up_dn = 1'b1;
    en = 1'b1;
    step(1);
    check("hold_presc3", 32'(value_bcd), 32'h05);
    step(1);
    check("hold_tick", 32'(value_bcd), 32'h06);
    en = 1'b0;
    do_reset();
    en = 1'b1;
    step(20);
    en = 1'b0;
    check("scan_value", 32'(value_bcd), 32'h05);
    wait_an(2'b10, "scan_find10");
    check("seg_digit0", 32'(seg), 32'(7'b0010010));
    wait_an(2'b01, "scan_find01");
    // 6: upper digit is a leading zero
`ifdef SEG7_LEADING_BLANK_EN
    check("seg_digit1", 32'(seg), 32'h7F);
`else
    check("seg_digit1", 32'(seg), 32'(7'b1000000));
`endif
    step(1);
    check("an_01_b", 32'(an), 32'h1);
    step(1);
    check("an_10_a", 32'(an), 32'h2);
    check("seg_digit0_b", 32'(seg), 32'(7'b0010010));
    step(1);
    check("an_10_b", 32'(an), 32'h2);
    step(1);
    check("an_01_c", 32'(an), 32'h1);
    check("hold_scan_value", 32'(value_bcd), 32'h05);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
